// File: rtl/packet_builder_pkg.sv
// packet_builder_pkg
//   Shared types and sizing helpers for packet_builder. The sizing functions
//   are also used by packet_parser benches, which need the same framing sizes.
//   Contents:
//     BYTE_BITS   - bits per wire byte
//     pb_state_e  - builder FSM state (IDLE / BODY / FLUSH)
//     hdr_bytes   - total header length H = A + B
//     buf_bytes   - staging buffer size in bytes, H + W
//     cnt_bits    - width of a counter that can hold 0 .. H + W
package packet_builder_pkg;

  localparam int BYTE_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BODY  = 2'd1,
    ST_FLUSH = 2'd2
  } pb_state_e;

  function automatic int hdr_bytes(input int a_bytes, input int b_bytes);
    return a_bytes + b_bytes;
  endfunction

  function automatic int buf_bytes(input int a_bytes, input int b_bytes, input int w_bytes);
    return a_bytes + b_bytes + w_bytes;
  endfunction

  function automatic int cnt_bits(input int a_bytes, input int b_bytes, input int w_bytes);
    return $clog2(a_bytes + b_bytes + w_bytes + 1);
  endfunction

endpackage

// File: rtl/packet_builder_byteen_count.sv
// byteen_count
//   Counts the leading (MSB-first) ones of a byte-enable vector and reports
//   whether the vector is a contiguous run of ones starting at the MSB.
//   Ports:
//     byteen   in  W   byte enables, MSB byte first on the wire
//     lead_cnt out CW  number of consecutive ones starting at bit W-1
//     contig   out 1   1 when byteen has no ones below its first zero
module byteen_count #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  byteen,
  output logic [CW-1:0] lead_cnt,
  output logic          contig
);

  logic [W-1:0] lead_mask;
  logic         seen_zero;

  always_comb begin
    lead_cnt  = '0;
    lead_mask = '0;
    seen_zero = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (byteen[i] && !seen_zero) begin
        lead_cnt     = lead_cnt + CW'(1);
        lead_mask[i] = 1'b1;
      end else begin
        seen_zero = 1'b1;
      end
    end
    // Any enable set below the first zero breaks contiguity.
    contig = (byteen == lead_mask);
  end

endmodule

// File: rtl/packet_builder.sv
// packet_builder
//   Prepends header A then header B to a payload stream and emits the
//   combined packet, byte W-1 of each bus word first on the wire.
//   Ports:
//     clk_host, rst_n          clock, asynchronous active-low reset
//     bus_in_valid/ready       payload handshake
//     bus_in_sop/eop           payload first / last beat
//     bus_in_byteen/data       payload byte enables / data
//     headerA, headerB         headers, used on the accepted sop beat
//     bus_out_valid/sop/eop    output beat framing (no backpressure)
//     bus_out_byteen/data      output byte enables / data (disabled bytes 0)
//     proto_err                one-cycle protocol error pulse
//     dbg_state                current FSM state
//
// Handshake: a payload beat transfers on a rising edge where bus_in_valid and
// bus_in_ready are both 1; bus_in_ready is 0 only while the FSM is in FLUSH
// and does not depend on bus_in_valid. Output beats are presented for exactly
// one cycle with bus_out_valid = 1 and cannot be stalled.
module packet_builder
  import packet_builder_pkg::*;
#(
  parameter int WIDTH_DATA_BYTES  = 8,
  parameter int WIDTH_HDR_A_BYTES = 6,
  parameter int WIDTH_HDR_B_BYTES = 4
) (
  input  logic                                      clk_host,
  input  logic                                      rst_n,
  input  logic                                      bus_in_valid,
  output logic                                      bus_in_ready,
  input  logic                                      bus_in_sop,
  input  logic                                      bus_in_eop,
  input  logic [WIDTH_DATA_BYTES-1:0]               bus_in_byteen,
  input  logic [BYTE_BITS*WIDTH_DATA_BYTES-1:0]     bus_in_data,
  input  logic [BYTE_BITS*WIDTH_HDR_A_BYTES-1:0]    headerA,
  input  logic [BYTE_BITS*WIDTH_HDR_B_BYTES-1:0]    headerB,
  output logic                                      bus_out_valid,
  output logic                                      bus_out_sop,
  output logic                                      bus_out_eop,
  output logic [WIDTH_DATA_BYTES-1:0]               bus_out_byteen,
  output logic [BYTE_BITS*WIDTH_DATA_BYTES-1:0]     bus_out_data,
  output logic                                      proto_err,
  output pb_state_e                                 dbg_state
);

  localparam int W  = WIDTH_DATA_BYTES;
  localparam int H  = hdr_bytes(WIDTH_HDR_A_BYTES, WIDTH_HDR_B_BYTES);
  localparam int BB = buf_bytes(WIDTH_HDR_A_BYTES, WIDTH_HDR_B_BYTES, W);
  localparam int CW = cnt_bits(WIDTH_HDR_A_BYTES, WIDTH_HDR_B_BYTES, W);
  localparam int LW = $clog2(W + 1);

  localparam logic [CW-1:0] W_C = CW'(W);
  localparam logic [CW-1:0] H_C = CW'(H);

  // Registered state
  pb_state_e              state_q, state_d;
  logic [BYTE_BITS*BB-1:0] buf_q, buf_d;       // first wire byte at the MSB end
  logic [CW-1:0]          occ_q, occ_d;
  logic                   sop_pend_q, sop_pend_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_sop_q, out_sop_d;
  logic                   out_eop_q, out_eop_d;
  logic [W-1:0]           out_be_q, out_be_d;
  logic [BYTE_BITS*W-1:0] out_data_q, out_data_d;
  logic                   proto_err_q, proto_err_d;

  // Datapath intermediates
  logic [LW-1:0]           lead_cnt;
  logic                    be_contig;
  logic                    accept, take, active, is_final, emit, done;
  logic [W-1:0]            in_be_mask;
  logic [BYTE_BITS*W-1:0]  in_masked;
  logic [BYTE_BITS*BB-1:0] base_v, in_ext, stream;
  logic [CW-1:0]           base_cnt, in_cnt, src_cnt, emit_cnt;
  logic                    src_ge_w;

  byteen_count #(.W(W), .CW(LW)) u_byteen_count (
    .byteen   (bus_in_byteen),
    .lead_cnt (lead_cnt),
    .contig   (be_contig)
  );

  assign bus_in_ready = (state_q != ST_FLUSH);

  // Merge the held bytes (or the headers, when starting a packet) with the
  // valid bytes of the incoming beat, and decide how many bytes leave now.
  always_comb begin
    accept = bus_in_valid && bus_in_ready;
    // In IDLE only a sop beat starts a packet; anything else is dropped.
    take   = accept && ((state_q != ST_IDLE) || bus_in_sop);

    // A non-contiguous eop byteen is trusted only up to its first zero.
    in_be_mask = bus_in_eop ? ~({W{1'b1}} >> lead_cnt) : {W{1'b1}};
    in_masked  = '0;
    for (int b = 0; b < W; b++) begin
      in_masked[BYTE_BITS*b +: BYTE_BITS] = in_be_mask[b] ? bus_in_data[BYTE_BITS*b +: BYTE_BITS]
                                                          : {BYTE_BITS{1'b0}};
    end
    in_cnt = !take ? '0 : (bus_in_eop ? CW'(lead_cnt) : W_C);

    if (state_q == ST_IDLE) begin
      base_v   = {headerA, headerB, {(BYTE_BITS*W){1'b0}}};
      base_cnt = H_C;
    end else begin
      base_v   = buf_q;
      base_cnt = occ_q;
    end

    // Bytes past the held count are zero, so the beat can be OR-ed in place.
    in_ext   = take ? ({in_masked, {(BYTE_BITS*H){1'b0}}} >> {base_cnt, 3'b000}) : '0;
    stream   = base_v | in_ext;
    src_cnt  = base_cnt + in_cnt;
    src_ge_w = (src_cnt >= W_C);

    active   = take || (state_q != ST_IDLE);
    is_final = (state_q == ST_FLUSH) || (take && bus_in_eop);
    emit     = active && (is_final || src_ge_w);
    emit_cnt = !emit ? '0 : (src_ge_w ? W_C : src_cnt);
    done     = is_final && (src_cnt <= W_C);
  end

  // State register
  always_ff @(posedge clk_host or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = done ? ST_IDLE : (is_final ? ST_FLUSH : ST_BODY);
        end
      end
      ST_BODY: begin
        if (is_final) begin
          state_d = done ? ST_IDLE : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and buffer update logic
  always_comb begin
    out_valid_d = emit;
    out_sop_d   = emit && ((state_q == ST_IDLE) || sop_pend_q);
    out_eop_d   = emit && done;
    out_be_d    = emit ? ~({W{1'b1}} >> emit_cnt) : '0;
    out_data_d  = '0;
    for (int b = 0; b < W; b++) begin
      out_data_d[BYTE_BITS*b +: BYTE_BITS] =
        out_be_d[b] ? stream[BYTE_BITS*(BB-W) + BYTE_BITS*b +: BYTE_BITS] : {BYTE_BITS{1'b0}};
    end

    if (!active || done) begin
      occ_d = '0;
      buf_d = '0;
    end else begin
      occ_d = src_cnt - emit_cnt;
      buf_d = stream << {emit_cnt, 3'b000};
    end

    // Remembers that the first beat is still owed sop when the headers
    // alone do not fill a bus word.
    if (state_q == ST_IDLE) begin
      sop_pend_d = take && !emit;
    end else if (emit) begin
      sop_pend_d = 1'b0;
    end else begin
      sop_pend_d = sop_pend_q;
    end

    proto_err_d = (accept && (state_q == ST_IDLE) && !bus_in_sop)
               || (accept && (state_q == ST_BODY) && bus_in_sop)
               || (take && bus_in_eop && !be_contig);
  end

  always_ff @(posedge clk_host or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      occ_q       <= '0;
      sop_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_be_q    <= '0;
      out_data_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      occ_q       <= occ_d;
      sop_pend_q  <= sop_pend_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_be_q    <= out_be_d;
      out_data_q  <= out_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus_out_valid  = out_valid_q;
  assign bus_out_sop    = out_sop_q;
  assign bus_out_eop    = out_eop_q;
  assign bus_out_byteen = out_be_q;
  assign bus_out_data   = out_data_q;
  assign proto_err      = proto_err_q;
  assign dbg_state      = state_q;

endmodule
